// File: rtl/photon_counter_pkg.sv
// Shared types and constants for the multi-channel pattern photon counter.
package photon_counter_pkg;

  // Acquisition FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StCount
  } acq_state_e;

  // Default parameter values.
  localparam int unsigned DefChannels   = 2;
  localparam int unsigned DefCntW       = 16;
  localparam int unsigned DefDepth      = 1024;
  localparam int unsigned DefSyncStages = 2;

  // Width of one packed frame (all channels side by side, channel 0 in the LSBs).
  function automatic int unsigned frame_width(input int unsigned channels,
                                              input int unsigned cnt_w);
    return channels * cnt_w;
  endfunction

  // LSB position of a channel's count inside a packed frame.
  function automatic int unsigned chan_lsb(input int unsigned chan, input int unsigned cnt_w);
    return chan * cnt_w;
  endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Synchroniser chain for one asynchronous input plus a rising-edge detector that
// yields a single-cycle pulse per low-to-high transition.
module pulse_sync_edge
  import photon_counter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the async level through the synchroniser and remember the last synced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/pattern_photon_counter.sv
// Per-channel photon counter windowed by DMD pattern boundaries, with a circular
// frame buffer and a channel-serial valid/ready readout.
module pattern_photon_counter
  import photon_counter_pkg::*;
#(
  parameter int unsigned CHANNELS    = DefChannels,
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned DEPTH       = DefDepth,
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         dmd_sig,
  input  logic [CHANNELS-1:0]          sig,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic [CNT_W-1:0]             rd_data,
  output logic [$clog2(CHANNELS):0]    rd_chan,
  output logic                         rd_last,
  output logic [$clog2(DEPTH):0]       frames,
  output logic                         full,
  output logic                         overflow,
  output logic [CHANNELS-1:0]          sat
);

  localparam int unsigned FrameW  = frame_width(CHANNELS, CNT_W);
  localparam int unsigned AddrW   = $clog2(DEPTH);
  localparam int unsigned FramesW = AddrW + 1;
  localparam int unsigned ChanW   = $clog2(CHANNELS) + 1;
  localparam logic [CNT_W-1:0]   CntMax     = '1;
  localparam logic [ChanW-1:0]   LastChan   = ChanW'(CHANNELS - 1);
  localparam logic [FramesW-1:0] FramesFull = FramesW'(DEPTH);

  logic [CHANNELS-1:0] sig_pulse;
  logic                dmd_pulse;

  for (genvar g = 0; g < CHANNELS; g++) begin : gen_sig_sync
    pulse_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sig_sync (
      .clk     (clk),
      .rst     (rst),
      .async_in(sig[g]),
      .pulse   (sig_pulse[g])
    );
  end

  pulse_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dmd_sync (
    .clk     (clk),
    .rst     (rst),
    .async_in(dmd_sig),
    .pulse   (dmd_pulse)
  );

  // ---------------------------------------------------------------- acquisition FSM
  acq_state_e state_q, state_d;
  logic cnt_load, cnt_inc, snap;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next state: dropping en always returns to idle, discarding the open window.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StArmed;
        StArmed: if (dmd_pulse) state_d = StCount;
        StCount: state_d = StCount;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs: a boundary loads the counters with this cycle's photons so a
  // coincident photon lands in the new window.
  always_comb begin
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    snap     = 1'b0;
    if (en) begin
      unique case (state_q)
        StIdle:  ;
        StArmed: cnt_load = dmd_pulse;
        StCount: begin
          snap     = dmd_pulse;
          cnt_load = dmd_pulse;
          cnt_inc  = ~dmd_pulse;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- counters
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] sat_q, sat_set;
  logic [FrameW-1:0]   snap_frame;

  // Saturating counter next state; anything other than load/increment holds at zero.
  always_comb begin
    sat_set    = '0;
    snap_frame = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      cnt_d[c] = '0;
      if (cnt_load) begin
        cnt_d[c] = CNT_W'(sig_pulse[c]);
      end else if (cnt_inc) begin
        cnt_d[c] = cnt_q[c];
        if (sig_pulse[c]) begin
          if (cnt_q[c] == CntMax) sat_set[c] = 1'b1;
          else                    cnt_d[c]   = cnt_q[c] + CNT_W'(1);
        end
      end
      snap_frame[chan_lsb(c, CNT_W) +: CNT_W] = cnt_q[c];
    end
  end

  // Counter and sticky saturation registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
      sat_q <= '0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) cnt_q[c] <= cnt_d[c];
      sat_q <= sat_q | sat_set;
    end
  end

  // ---------------------------------------------------------------- frame buffer
  logic                wr_en_q;
  logic [FrameW-1:0]   wr_data_q;
  logic [AddrW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [FramesW-1:0]  frames_q, frames_d;
  logic [ChanW-1:0]    chan_q, chan_d;
  logic                rd_valid_q, rd_valid_d, ovf_q;
  logic                buf_full, xfer, pop, wr_ok;
  logic [FrameW-1:0]   mem [DEPTH];
  logic [FrameW-1:0]   ram_q;
  logic [CNT_W-1:0]    rd_word;

  // Snapshot the finished window one cycle before it is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= snap;
      if (snap) wr_data_q <= snap_frame;
    end
  end

  // Buffer bookkeeping: a pop frees the slot before a same-cycle write is judged.
  always_comb begin
    buf_full   = (frames_q == FramesFull);
    xfer       = rd_valid_q & rd_ready;
    pop        = xfer && (chan_q == LastChan);
    wr_ok      = wr_en_q && (!buf_full || pop);
    frames_d   = frames_q + FramesW'(wr_ok) - FramesW'(pop);
    rd_ptr_d   = pop ? rd_ptr_q + AddrW'(1) : rd_ptr_q;
    chan_d     = xfer ? (pop ? '0 : chan_q + ChanW'(1)) : chan_q;
    // Only frames written at an earlier edge are readable through the RAM register.
    rd_valid_d = (frames_q > FramesW'(pop));
  end

  // Inferred block RAM write port.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data_q;
  end

  // Registered RAM read, addressed by the next head so the following frame is prefetched.
  always_ff @(posedge clk) begin
    if (rst) ram_q <= '0;
    else     ram_q <= mem[rd_ptr_d];
  end

  // Pointer, occupancy, serialiser and overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      frames_q   <= '0;
      chan_q     <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      rd_ptr_q   <= rd_ptr_d;
      frames_q   <= frames_d;
      chan_q     <= chan_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_q | (wr_en_q & ~wr_ok);
    end
  end

  // Select the current channel's count from the head frame.
  always_comb begin
    rd_word = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (chan_q == ChanW'(c)) rd_word = ram_q[chan_lsb(c, CNT_W) +: CNT_W];
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? rd_word : '0;
  assign rd_chan  = rd_valid_q ? chan_q : '0;
  assign rd_last  = rd_valid_q && (chan_q == LastChan);
  assign frames   = frames_q;
  assign full     = buf_full;
  assign overflow = ovf_q;
  assign sat      = sat_q;

endmodule
